// File: rtl/mem_writeback_bridge_if.sv
// Cache/Ram-side bus of the write-back bridge.
// The slave view belongs to the bridge; the master view to the cache and Ram around it.
interface mem_writeback_bridge_if #(
   parameter int WIDTH    = 32,
   parameter int AWIDTH   = 32,
   parameter int RAM_AW   = 16,
   parameter int WB_DEPTH = 4
);
   localparam int CW = $clog2(WB_DEPTH) + 1;

   // Cache memory port
   logic              mrden;
   logic [AWIDTH-1:0] mrdaddress;
   logic              mwren;
   logic [AWIDTH-1:0] mwraddress;
   logic [WIDTH-1:0]  mdout;
   logic [WIDTH-1:0]  mq;

   // Single-port Ram
   logic [RAM_AW-1:0] ram_addr;
   logic [WIDTH-1:0]  ram_din;
   logic              ram_we;
   logic              ram_re;
   logic [WIDTH-1:0]  ram_dout;
   logic              ram_valid;

   // Write-back queue status
   logic [CW-1:0]     wb_count;
   logic              wb_empty;
   logic              wb_full;
   logic              overflow_err;

   modport slave (
      input  mrden, mrdaddress, mwren, mwraddress, mdout, ram_dout, ram_valid,
      output mq, ram_addr, ram_din, ram_we, ram_re, wb_count, wb_empty, wb_full, overflow_err
   );

   modport master (
      output mrden, mrdaddress, mwren, mwraddress, mdout, ram_dout, ram_valid,
      input  mq, ram_addr, ram_din, ram_we, ram_re, wb_count, wb_empty, wb_full, overflow_err
   );
endinterface

// File: rtl/mem_writeback_bridge.sv
// Write-back bridge between the cache memory port and a single-port Ram.
// Write-backs are queued in a coalescing FIFO and drained only in cycles without a
// refill read; refill reads that hit a queued (or same-cycle) write are forwarded.
module mem_writeback_bridge #(
   parameter int WIDTH    = 32,
   parameter int AWIDTH   = 32,
   parameter int RAM_AW   = 16,
   parameter int WB_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   mem_writeback_bridge_if.slave bus
);
   localparam int PW = $clog2(WB_DEPTH);
   localparam int CW = PW + 1;

   // FIFO storage and control
   logic [RAM_AW-1:0] addr_q [WB_DEPTH];
   logic [WIDTH-1:0]  data_q [WB_DEPTH];
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              empty_q, full_q;
   logic              overflow_q, overflow_d;

   // Read pipeline
   logic              rd_pend_q;
   logic              fwd_hit_q, fwd_hit_d;
   logic [WIDTH-1:0]  fwd_data_q, fwd_data_d;
   logic [WIDTH-1:0]  mq_q;

   logic [WB_DEPTH-1:0] valid;
   logic [RAM_AW-1:0]   rd_addr, wr_addr;
   logic                wr_hit;
   logic [PW-1:0]       wr_hit_idx;
   logic                fifo_full, drain, enq, pop;

   assign rd_addr   = bus.mrdaddress[RAM_AW-1:0];
   assign wr_addr   = bus.mwraddress[RAM_AW-1:0];
   assign fifo_full = (count_q == CW'(WB_DEPTH));

   // Mark the entries that lie between the read pointer and read pointer + count
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      valid = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         valid[i] = {1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q;
      end
   end

   // Address match of the incoming write (coalesce) and of the refill read (forward)
   always_comb begin
      wr_hit     = 1'b0;
      wr_hit_idx = '0;
      fwd_hit_d  = 1'b0;
      fwd_data_d = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         if (valid[i] && addr_q[i] == wr_addr) begin
            wr_hit     = 1'b1;
            wr_hit_idx = PW'(i);
         end
         if (valid[i] && addr_q[i] == rd_addr) begin
            fwd_hit_d  = 1'b1;
            fwd_data_d = data_q[i];
         end
      end
      // A write arriving in the same cycle is newer than anything queued
      if (bus.mwren && wr_addr == rd_addr) begin
         fwd_hit_d  = 1'b1;
         fwd_data_d = bus.mdout;
      end
   end

   // Queue bookkeeping: enqueue, drop, drain and pop decisions
   always_comb begin
      drain      = !bus.mrden && (count_q != '0);
      enq        = bus.mwren && !wr_hit && !fifo_full;
      overflow_d = overflow_q | (bus.mwren && !wr_hit && fifo_full);
      // A coalesce onto the head keeps it queued so the fresh data is drained later
      pop        = drain && !(bus.mwren && wr_hit && wr_hit_idx == rd_ptr_q);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      wr_ptr_d   = wr_ptr_q + PW'(enq);
      count_d    = count_q + CW'(enq) - CW'(pop);
   end

   // Ram port: reads win, otherwise the head entry is written back
   always_comb begin
      bus.ram_re   = reset_n && bus.mrden;
      bus.ram_we   = reset_n && drain;
      bus.ram_addr = bus.mrden ? rd_addr : addr_q[rd_ptr_q];
      bus.ram_din  = data_q[rd_ptr_q];
   end

   // FIFO payload: coalesce in place or append at the write pointer
   always_ff @(posedge clk) begin
      // NOTE: payload storage has no reset; validity comes solely from the reset pointers/count.
      if (bus.mwren && wr_hit) begin
         data_q[wr_hit_idx] <= bus.mdout;
      end else if (enq) begin
         addr_q[wr_ptr_q] <= wr_addr;
         data_q[wr_ptr_q] <= bus.mdout;
      end
   end

   // Control state, status flags and the refill pipeline
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         rd_pend_q  <= 1'b0;
         fwd_hit_q  <= 1'b0;
         fwd_data_q <= '0;
         mq_q       <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         empty_q    <= (count_d == '0);
         full_q     <= (count_d == CW'(WB_DEPTH));
         overflow_q <= overflow_d;
         rd_pend_q  <= bus.mrden;
         if (bus.mrden) begin
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
         end
         if (rd_pend_q) begin
            mq_q <= fwd_hit_q ? fwd_data_q : bus.ram_dout;
         end
      end
   end

   assign bus.mq           = mq_q;
   assign bus.wb_count     = count_q;
   assign bus.wb_empty     = empty_q;
   assign bus.wb_full      = full_q;
   assign bus.overflow_err = overflow_q;
endmodule
